// File: rtl/npc_ctrl.sv
// npc_ctrl: right-side NPC for PikaBall. It tracks the ball in x and jumps with fixed-point gravity physics.
// Optional feature NPC_PREDICT_EN: aim at a linearly extrapolated ball x instead of the current ball x.
module npc_ctrl #(
  parameter int unsigned VBUF_W     = 320,
  parameter int unsigned NET_X      = 160,
  parameter int unsigned NPC_W      = 41,
  parameter int unsigned GROUND_Y   = 199,
  parameter int unsigned H_STEP     = 2,
  parameter int unsigned FRAC_BITS  = 4,
  parameter int unsigned JUMP_V     = 96,
  parameter int unsigned GRAVITY    = 8,
  parameter int unsigned JUMP_RANGE = 24,
  parameter int unsigned JUMP_Y_MAX = 150,
  parameter int unsigned COOLDOWN   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        phys_tick,
  input  logic [11:0] ball_pos_x,
  input  logic [11:0] ball_pos_y,
  output logic [11:0] npc_pos_x,
  output logic [11:0] npc_pos_y,
  output logic        airborne,
  output logic [1:0]  fsm_state
);

  localparam int unsigned POS_W = 12;
  localparam int unsigned XW    = POS_W + 1;
  localparam int unsigned Y_W   = POS_W + FRAC_BITS;
  localparam int unsigned YW1   = Y_W + 1;
  localparam int unsigned VEL_W = FRAC_BITS + 8;
  localparam int unsigned CD_W  = $clog2(COOLDOWN + 2);

  localparam logic [POS_W-1:0] X_RST = POS_W'(VBUF_W - NPC_W - 1);
  localparam logic [XW-1:0]    X_MIN = XW'(NET_X);
  localparam logic [XW-1:0]    X_MAX = XW'(VBUF_W - NPC_W);
  localparam logic [Y_W-1:0]   Y_GND = Y_W'(GROUND_Y << FRAC_BITS);
  localparam logic [VEL_W-1:0] GRAV  = VEL_W'(GRAVITY);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2,
    ST_BAD    = 2'd3
  } state_t;

  state_t           state_q, st_d;
  logic [POS_W-1:0] x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [VEL_W-1:0] vel_q, vel_d, vel_up;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic             airborne_q, airborne_d;
  logic             step, jump_ok;
  logic [POS_W-1:0] target, hdist, hstep;
  logic [XW-1:0]    x_mv;
  logic [YW1-1:0]   y_sum;

  function automatic logic [POS_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                input logic [POS_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  assign step = enable & phys_tick;

`ifdef NPC_PREDICT_EN
  localparam logic signed [15:0] TGT_MAX = 16'(VBUF_W - 1);

  logic [POS_W-1:0]   prev_x_q;
  logic               prev_vld_q;
  logic signed [12:0] dx;
  logic signed [15:0] tgt_s;

  // Extrapolate four steps ahead from the last observed ball motion.
  always_comb begin
    dx     = 13'sd0;
    tgt_s  = 16'sd0;
    target = ball_pos_x;
    if (prev_vld_q)
      dx = $signed({1'b0, ball_pos_x}) - $signed({1'b0, prev_x_q});
    tgt_s = $signed({4'b0, ball_pos_x}) + ($signed(16'(dx)) <<< 2);
    if (tgt_s < 16'sd0)
      target = '0;
    else if (tgt_s > TGT_MAX)
      target = POS_W'(VBUF_W - 1);
    else
      target = tgt_s[POS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_x_q   <= '0;
      prev_vld_q <= 1'b0;
    end else if (step) begin
      prev_x_q   <= ball_pos_x;
      prev_vld_q <= 1'b1;
    end
  end
`else
  assign target = ball_pos_x;
`endif

  // Horizontal chase: bounded step toward the target, kept inside the right half-court.
  always_comb begin
    x_d   = x_q;
    hdist = abs_diff(target, x_q);
    hstep = (hdist > POS_W'(H_STEP)) ? POS_W'(H_STEP) : hdist;
    x_mv  = (target >= x_q) ? ({1'b0, x_q} + {1'b0, hstep})
                            : ({1'b0, x_q} - {1'b0, hstep});
    if (x_mv < X_MIN)
      x_d = POS_W'(NET_X);
    else if (x_mv > X_MAX)
      x_d = POS_W'(VBUF_W - NPC_W);
    else
      x_d = x_mv[POS_W-1:0];
  end

  assign jump_ok = (abs_diff(ball_pos_x, x_q) <= POS_W'(JUMP_RANGE)) &&
                   (ball_pos_y <= POS_W'(JUMP_Y_MAX));

  // Vertical physics and jump FSM next-state.
  always_comb begin
    st_d       = state_q;
    y_d        = y_q;
    vel_d      = vel_q;
    cd_d       = cd_q;
    vel_up     = vel_q + GRAV;
    y_sum      = YW1'(y_q) + YW1'(vel_up);
    airborne_d = 1'b0;
    case (state_q)
      ST_GROUND: begin
        if (cd_q != '0) begin
          cd_d = cd_q - CD_W'(1);
        end else if (jump_ok) begin
          vel_d = VEL_W'(JUMP_V);
          st_d  = ST_RISE;
        end
      end
      ST_RISE: begin
        y_d = (Y_W'(vel_q) > y_q) ? '0 : y_q - Y_W'(vel_q);
        if (vel_q > GRAV) begin
          vel_d = vel_q - GRAV;
        end else begin
          vel_d = '0;
          st_d  = ST_FALL;
        end
      end
      ST_FALL: begin
        if (y_sum >= YW1'(Y_GND)) begin
          y_d   = Y_GND;
          vel_d = '0;
          cd_d  = CD_W'(COOLDOWN);
          st_d  = ST_GROUND;
        end else begin
          y_d   = y_sum[Y_W-1:0];
          vel_d = vel_up;
        end
      end
      default: begin
        y_d   = Y_GND;
        vel_d = '0;
        st_d  = ST_GROUND;
      end
    endcase
    airborne_d = (st_d == ST_RISE) || (st_d == ST_FALL);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_GROUND;
      x_q        <= X_RST;
      y_q        <= Y_GND;
      vel_q      <= '0;
      cd_q       <= '0;
      airborne_q <= 1'b0;
    end else if (step) begin
      state_q    <= st_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vel_q      <= vel_d;
      cd_q       <= cd_d;
      airborne_q <= airborne_d;
    end
  end

  assign npc_pos_x = x_q;
  assign npc_pos_y = y_q[Y_W-1:FRAC_BITS];
  assign airborne  = airborne_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_npc_ctrl.sv
// tb_npc_ctrl: checks npc_ctrl against an integer reference model using directed and randomized stimulus.
module tb_npc_ctrl;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        phys_tick;
  logic [11:0] ball_pos_x;
  logic [11:0] ball_pos_y;
  logic [11:0] npc_pos_x;
  logic [11:0] npc_pos_y;
  logic        airborne;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;

  // Reference model state: plain integers, with y and velocity in sixteenths of a pixel.
  int m_x, m_y, m_vel, m_cd, m_st, m_prev;
  bit m_prev_vld;
  bit m_live = 1'b0;

  npc_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .phys_tick  (phys_tick),
    .ball_pos_x (ball_pos_x),
    .ball_pos_y (ball_pos_y),
    .npc_pos_x  (npc_pos_x),
    .npc_pos_y  (npc_pos_y),
    .airborne   (airborne),
    .fsm_state  (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rn, input bit en, input bit tk, input int bx, input int by);
    int tgt, d, mv, nx, dx;
    if (!rn) begin
      m_x = 278; m_y = 199 * 16; m_vel = 0; m_cd = 0; m_st = 0;
      m_prev = 0; m_prev_vld = 1'b0; m_live = 1'b1;
      return;
    end
    if (!(en && tk)) return;
    tgt = bx;
`ifdef NPC_PREDICT_EN
    dx = m_prev_vld ? bx - m_prev : 0;
    tgt = clampi(bx + 4 * dx, 0, 319);
`else
    dx = 0;
`endif
    m_prev = bx;
    m_prev_vld = 1'b1;
    d  = tgt - m_x + dx * 0;
    mv = (absi(d) < 2) ? absi(d) : 2;
    nx = clampi(m_x + ((d < 0) ? -mv : mv), 160, 279);
    case (m_st)
      0: begin
        if (m_cd > 0) m_cd = m_cd - 1;
        else if (absi(bx - m_x) <= 24 && by <= 150) begin
          m_vel = 96; m_st = 1;
        end
      end
      1: begin
        m_y = (m_y - m_vel < 0) ? 0 : m_y - m_vel;
        if (m_vel > 8) m_vel = m_vel - 8;
        else begin m_vel = 0; m_st = 2; end
      end
      default: begin
        m_vel = m_vel + 8;
        m_y = m_y + m_vel;
        if (m_y / 16 >= 199) begin
          m_y = 199 * 16; m_vel = 0; m_cd = 16; m_st = 0;
        end
      end
    endcase
    m_x = nx;
  endtask

  // One clock cycle of stimulus; the model advances on the same edge as the DUT.
  task automatic cyc(input bit rn, input bit en, input bit tk);
    reset_n = rn; enable = en; phys_tick = tk;
    @(posedge clk);
    model_edge(rn, en, tk, int'(ball_pos_x), int'(ball_pos_y));
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1);
  endtask

  task automatic set_ball(input int bx, input int by);
    ball_pos_x = 12'(bx);
    ball_pos_y = 12'(by);
  endtask

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_live) begin
      chk("model_x", 32'(npc_pos_x), m_x);
      chk("model_y", 32'(npc_pos_y), m_y / 16);
      chk("model_state", 32'(fsm_state), m_st);
      chk("model_airborne", 32'(airborne), (m_st != 0) ? 1 : 0);
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; phys_tick = 1'b0;
    set_ball(300, 300);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    chk("rst_x", 32'(npc_pos_x), 278);
    chk("rst_y", 32'(npc_pos_y), 199);
    chk("rst_state", 32'(fsm_state), 0);
    chk("rst_airborne", 32'(airborne), 0);

    // Right clamp.
    ticks(1);
    chk("clamp_r_t1", 32'(npc_pos_x), 279);
    ticks(2);
    chk("clamp_r_t3", 32'(npc_pos_x), 279);
    chk("clamp_r_y", 32'(npc_pos_y), 199);

    // Idle cycles with no tick leave the position alone.
    set_ball(0, 230);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("no_tick_hold", 32'(npc_pos_x), 279);

    // Run left to the net.
    cyc(1'b0, 1'b1, 1'b0);
    ticks(1);
    chk("left_t1", 32'(npc_pos_x), 276);
    ticks(58);
    chk("left_t59", 32'(npc_pos_x), 160);
    ticks(1);
    chk("left_t60", 32'(npc_pos_x), 160);

    // Full jump arc.
    set_ball(300, 300);
    cyc(1'b0, 1'b1, 1'b0);
    ticks(1);
    set_ball(279, 100);
    ticks(1);
    chk("jump_start_state", 32'(fsm_state), 1);
    chk("jump_start_y", 32'(npc_pos_y), 199);
    chk("jump_start_air", 32'(airborne), 1);
    ticks(11);
    chk("rise11_state", 32'(fsm_state), 1);
    ticks(1);
    chk("apex_state", 32'(fsm_state), 2);
    chk("apex_y", 32'(npc_pos_y), 160);
    ticks(11);
    chk("fall11_y", 32'(npc_pos_y), 193);
    chk("fall11_state", 32'(fsm_state), 2);
    ticks(1);
    chk("land_state", 32'(fsm_state), 0);
    chk("land_y", 32'(npc_pos_y), 199);
    chk("land_air", 32'(airborne), 0);

    // Cooldown after landing.
    ticks(16);
    chk("cooldown16_state", 32'(fsm_state), 0);
    ticks(1);
    chk("cooldown17_state", 32'(fsm_state), 1);

    // Freeze mid-rise with ticks present.
    ticks(3);
    chk("pre_freeze_y", 32'(npc_pos_y), 182);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1);
    chk("freeze_y", 32'(npc_pos_y), 182);
    chk("freeze_state", 32'(fsm_state), 1);
    chk("freeze_x", 32'(npc_pos_x), 279);
    ticks(9);
    chk("resume_apex_state", 32'(fsm_state), 2);
    chk("resume_apex_y", 32'(npc_pos_y), 160);

    // Reset mid-fall, coincident with a tick.
    ticks(5);
    cyc(1'b0, 1'b1, 1'b1);
    chk("midfall_rst_x", 32'(npc_pos_x), 278);
    chk("midfall_rst_y", 32'(npc_pos_y), 199);
    chk("midfall_rst_state", 32'(fsm_state), 0);
    ticks(1);
    chk("post_rst_jump", 32'(fsm_state), 1);

    // Randomized play, biased toward jump-triggering ball positions.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) ball_pos_x = 12'($urandom_range(0, 4095));
      else                           ball_pos_x = 12'($urandom_range(130, 320));
      if ($urandom_range(0, 3) != 0) ball_pos_y = 12'($urandom_range(60, 150));
      else                           ball_pos_y = 12'($urandom_range(151, 4095));
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 2) != 0));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npc_ctrl.md
Name: npc_ctrl

Overview:
Parametrised NPC (right-side player) controller for the PikaBall game. It tracks the ball horizontally within the right half-court and performs gravity-driven jumps using fixed-point vertical physics. A jump cooldown counter and a three-state vertical FSM control the jumps. Motion advances on a physics tick pulse, and the block feeds the sprite renderer and collision logic with integer pixel positions.

Parameters:
VBUF_W, 320, screen width in pixels
NET_X, 160, leftmost allowed npc_pos_x (net boundary)
NPC_W, 41, sprite width in pixels
GROUND_Y, 199, npc_pos_y when standing
H_STEP, 2, maximum horizontal pixels moved per tick
FRAC_BITS, 4, fractional bits of the vertical position and velocity
JUMP_V, 96, initial upward velocity (fixed point; 6.0 px/tick at default)
GRAVITY, 8, velocity change per tick (fixed point; 0.5 px/tick²)
JUMP_RANGE, 24, max |ball_pos_x - npc_pos_x| allowed to trigger a jump
JUMP_Y_MAX, 150, ball_pos_y must be <= this to trigger a jump
COOLDOWN, 16, ticks after landing before the next jump is allowed

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous, active-low reset
enable  input  1  game running; when low, all state is frozen
phys_tick  input  1  one-cycle physics step pulse
ball_pos_x  input  12  ball x, integer pixels
ball_pos_y  input  12  ball y, integer pixels
npc_pos_x  output  12  NPC x, integer pixels
npc_pos_y  output  12  NPC y, integer part of the fixed-point y
airborne  output  1  high when the FSM is in RISE or FALL
fsm_state  output  2  state code: GROUND=0, RISE=1, FALL=2

Behaviour:
- Reset is decided: reset_n is synchronous and active-low; clock is clk. Reset wins over tick and enable.
- Reset values: npc_pos_x = VBUF_W-NPC_W-1 (278); y = GROUND_Y<<FRAC_BITS; vel = 0; cooldown = 0; fsm_state = GROUND; airborne = 0.
- A step occurs only on a clk edge where enable=1 and phys_tick=1. Outputs are registered, with 1-cycle latency after the tick. No step is taken otherwise.
- Horizontal step, applied in every state. The target is ball_pos_x, or the predicted value when the optional feature is enabled.
  - diff = target - x. Move by min(H_STEP, |diff|) toward the target.
  - Clamp the result to [NET_X, VBUF_W-NPC_W].
  - diff = 0 gives no move.
  - Compute with a sign-extended 13-bit signed difference; no wrap-around.
- Vertical FSM; vel is unsigned with FRAC_BITS+8 bits:
  - GROUND: if cooldown != 0, decrement it. Else, if |ball_x - x| <= JUMP_RANGE and ball_y <= JUMP_Y_MAX, set vel = JUMP_V and go to RISE (y is unchanged this tick).
  - RISE: y -= vel. If vel > GRAVITY, vel -= GRAVITY; else vel = 0 and go to FALL. If the subtraction would underflow, clamp y to 0.
  - FALL: vel += GRAVITY, then y += new vel. If integer(y) >= GROUND_Y, set y = GROUND_Y<<FRAC_BITS, vel = 0, cooldown = COOLDOWN, and go to GROUND.
- The horizontal and vertical updates in the same tick are independent; both use the pre-tick x for the range check.
- enable low mid-jump: the FSM, vel, y and cooldown all hold; motion resumes exactly where it stopped.
- The unused state code 3 returns to GROUND with y = GROUND_Y and vel = 0 on the next tick.

Optional Feature:
NPC_PREDICT_EN
- Defined: the block registers the ball_pos_x seen on the previous step.
  - dx = ball_pos_x - prev_x (signed 13-bit).
  - target = ball_pos_x + (dx <<< 2), clamped to [0, VBUF_W-1].
  - prev_x resets to ball_pos_x on the first step after reset; the first step uses dx = 0.
- Undefined: target = ball_pos_x; no extra registers.

Test Plan:
- Reset then ball_pos_x=300 (no ball_y jump condition), 3 ticks -> x 278→279, then holds 279 (right clamp); y=199, fsm_state=0.
- ball_pos_x=0, ball_pos_y=230, 60 ticks -> x decreases by 2 per tick and reaches 160 at tick 59, then holds 160.
- x=279, ball_x=279, ball_y=100 -> RISE on the next tick. Apex y=160 is reached after 12 more ticks, and the FSM enters FALL. Landing at y=199 comes after 12 FALL ticks, with fsm_state=0 and airborne=0.
- Right after landing with the jump condition held -> no jump for 16 ticks; RISE occurs on the 17th tick.
- enable=0 for 10 cycles during RISE with ticks present -> x, y, vel and state are unchanged; the trajectory after re-enable is identical to the uninterrupted run.
- reset_n=0 asserted mid-FALL coincident with phys_tick -> next cycle x=278, y=199, fsm_state=0, cooldown=0.
